aes_block_sequencer: RTL and testbench

AES_BLOCK_SEQUENCER -- requirements
Module: aes_block_sequencer

---
 rtl/aes_block_sequencer_if.sv | 30 +++
 rtl/aes_block_sequencer.sv | 171 +++++++++++++++++
 tb/tb_aes_block_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_block_sequencer_if.sv
// rtl/aes_block_sequencer_if.sv - plaintext, AES core and ciphertext stream bundle
//
// Signal suffixes are from the sequencer's point of view.
//   in_*   : plaintext words into the sequencer (in_valid_i/in_ready_o/in_data_i)
//   core_* : AES core command/response (core_start_o/core_block_o, core_done_i/core_result_i)
//   out_*  : ciphertext words out of the sequencer (out_valid_o/out_ready_i/out_data_o)
// Modport slave is the sequencer side; modport master is the surrounding system side.

interface aes_block_sequencer_if;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [31:0]  in_data_i;
    logic         core_start_o;
    logic [127:0] core_block_o;
    logic         core_done_i;
    logic [127:0] core_result_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [31:0]  out_data_o;

    modport slave (
        input  in_valid_i, in_data_i, core_done_i, core_result_i, out_ready_i,
        output in_ready_o, core_start_o, core_block_o, out_valid_o, out_data_o
    );

    modport master (
        output in_valid_i, in_data_i, core_done_i, core_result_i, out_ready_i,
        input  in_ready_o, core_start_o, core_block_o, out_valid_o, out_data_o
    );
endinterface

// File: rtl/aes_block_sequencer.sv
// rtl/aes_block_sequencer.sv - splits a byte-length job into 128-bit AES blocks and streams them
//
// Ports:
//   clk, reset_n (async active-low), clear (sync soft reset)
//   start_i/byte_len_i : job start (accepted only in IDLE) and job length in bytes
//   busy_o, done_o     : job active, one-cycle completion pulse
//   blk_idx_o          : index of the block currently in process
//   bus (slave)        : plaintext in-stream, AES core command/response, ciphertext out-stream
// Build option:
//   AES_BLOCK_SEQ_PADDING_EN : a trailing partial block is fetched and zero-padded;
//                              otherwise trailing bytes (len mod 16) are never touched.

module aes_block_sequencer #(
    parameter int BLK_CNT_W = 28
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 start_i,
    input  logic [31:0]          byte_len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [BLK_CNT_W-1:0] blk_idx_o,
    aes_block_sequencer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_WAIT_CORE, S_DRAIN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [31:0]          len_q, len_d;
    logic [BLK_CNT_W-1:0] blk_idx_q, blk_idx_d, blk_idx_inc;
    logic [1:0]           word_cnt_q, word_cnt_d;
    logic [1:0]           out_cnt_q, out_cnt_d;
    logic [127:0]         block_q, block_d;
    logic [127:0]         result_q, result_d;
    logic                 in_fire, out_fire, last_word_in;
    logic [31:0]          in_word;

    // Number of blocks in a job of the given length, truncated to the counter width.
    function automatic logic [BLK_CNT_W-1:0] blk_total(input logic [31:0] len);
`ifdef AES_BLOCK_SEQ_PADDING_EN
        logic [32:0] rounded;
        rounded = {1'b0, len} + 33'd15;
        return BLK_CNT_W'(rounded >> 4);
`else
        return BLK_CNT_W'(len >> 4);
`endif
    endfunction

`ifdef AES_BLOCK_SEQ_PADDING_EN
    // Bytes of the job left from the start of the current block; only the final
    // block can have fewer than 16, so only it gets short-fetched and masked.
    logic [31:0] rem_bytes, word_base;
    assign rem_bytes = len_q - (32'(blk_idx_q) << 4);
    assign word_base = 32'({word_cnt_q, 2'b00});

    always_comb begin
        in_word = bus.in_data_i;
        for (int j = 0; j < 4; j++) begin
            if (word_base + 32'(j) >= rem_bytes) in_word[8*j +: 8] = 8'h00;
        end
    end

    assign last_word_in = (word_cnt_q == 2'd3) || (word_base + 32'd4 >= rem_bytes);
`else
    assign in_word      = bus.in_data_i;
    assign last_word_in = (word_cnt_q == 2'd3);
`endif

    assign in_fire     = bus.in_valid_i && (state_q == S_LOAD);
    assign out_fire    = bus.out_ready_i && (state_q == S_DRAIN);
    assign blk_idx_inc = blk_idx_q + BLK_CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        blk_idx_d  = blk_idx_q;
        word_cnt_d = word_cnt_q;
        out_cnt_d  = out_cnt_q;
        block_d    = block_q;
        result_d   = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    len_d      = byte_len_i;
                    blk_idx_d  = '0;
                    word_cnt_d = '0;
                    out_cnt_d  = '0;
                    block_d    = '0;
                    state_d    = (blk_total(byte_len_i) == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_fire) begin
                    block_d[{word_cnt_q, 5'd0} +: 32] = in_word;
                    if (last_word_in) begin
                        word_cnt_d = '0;
                        state_d    = S_RUN;
                    end else begin
                        word_cnt_d = word_cnt_q + 2'd1;
                    end
                end
            end
            S_RUN: state_d = S_WAIT_CORE;
            S_WAIT_CORE: begin
                if (bus.core_done_i) begin
                    result_d  = bus.core_result_i;
                    out_cnt_d = '0;
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_fire) begin
                    out_cnt_d = out_cnt_q + 2'd1;
                    if (out_cnt_q == 2'd3) begin
                        blk_idx_d = blk_idx_inc;
                        if (blk_idx_inc == blk_total(len_q)) begin
                            state_d = S_DONE;
                        end else begin
                            // Fresh block starts from zero so short final blocks are padded.
                            block_d = '0;
                            state_d = S_LOAD;
                        end
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (clear) begin
            state_d    = S_IDLE;
            len_d      = '0;
            blk_idx_d  = '0;
            word_cnt_d = '0;
            out_cnt_d  = '0;
            block_d    = '0;
            result_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            blk_idx_q  <= '0;
            word_cnt_q <= '0;
            out_cnt_q  <= '0;
            block_q    <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            blk_idx_q  <= blk_idx_d;
            word_cnt_q <= word_cnt_d;
            out_cnt_q  <= out_cnt_d;
            block_q    <= block_d;
            result_q   <= result_d;
        end
    end

    assign busy_o           = (state_q != S_IDLE);
    // clear in the DONE cycle must swallow the pulse, hence the combinational gate.
    assign done_o           = (state_q == S_DONE) && !clear;
    assign blk_idx_o        = blk_idx_q;
    assign bus.in_ready_o   = (state_q == S_LOAD);
    assign bus.core_start_o = (state_q == S_RUN);
    assign bus.core_block_o = block_q;
    assign bus.out_valid_o  = (state_q == S_DRAIN);
    assign bus.out_data_o   = (state_q == S_DRAIN) ? result_q[{out_cnt_q, 5'd0} +: 32] : 32'h0;
endmodule

// File: tb/tb_aes_block_sequencer.sv
// tb/tb_aes_block_sequencer.sv - self-checking bench for aes_block_sequencer

module tb_aes_block_sequencer;
    localparam int W = 28;

    logic         clk = 1'b0;
    logic         reset_n, clear, start_i;
    logic [31:0]  byte_len_i;
    logic         busy_o, done_o;
    logic [W-1:0] blk_idx_o;
    logic         core_done_real, spur_done, fire_in;
    logic [127:0] core_res_real, core_in;
    int           core_cnt;

    always #5 clk = ~clk;

    aes_block_sequencer_if bus();

    assign bus.core_done_i   = core_done_real | spur_done;
    assign bus.core_result_i = spur_done ? {4{32'hBAD0_BAD0}} : core_res_real;

    aes_block_sequencer #(.BLK_CNT_W(W)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .start_i(start_i),
        .byte_len_i(byte_len_i), .busy_o(busy_o), .done_o(done_o),
        .blk_idx_o(blk_idx_o), .bus(bus)
    );

    int total = 0, bad = 0;
    logic [31:0]  pool[10];
    logic [31:0]  src[$];
    logic [127:0] exp_blk[$], obs_blk[$];
    logic [31:0]  exp_out[$], obs_out[$];
    int           exp_out_blk[$];
    bit           exp_out_last[$];
    int exp_nblk = 0, exp_fetch = 0, fetched = 0, starts = 0, done_cnt = 0, out_seen = 0;
    int stall_after = 0, stall_left = 0, done_idx = 0;
    bit prev_valid = 0, prev_ready = 0, prev_done = 0, ready_chk = 0;
    logic [31:0] prev_data = '0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    // Whole-job model: which words are fetched, how each block looks, what comes out.
    function automatic void build_model(input logic [31:0] len);
        logic [127:0] blk, res;
        logic [31:0]  w;
        int           idx;
        longint       l;
        l = longint'(len);
`ifdef AES_BLOCK_SEQ_PADDING_EN
        exp_nblk  = int'((l + 15) / 16);
        exp_fetch = int'((l + 3) / 4);
`else
        exp_nblk  = int'(l / 16);
        exp_fetch = exp_nblk * 4;
`endif
        for (int b = 0; b < exp_nblk; b++) begin
            blk = '0;
            for (int k = 0; k < 4; k++) begin
                idx = 4 * b + k;
                if (idx < exp_fetch) begin
                    w = pool[idx];
                    for (int j = 0; j < 4; j++)
                        if (longint'(4 * idx + j) >= l) w[8*j +: 8] = 8'h00;
                    blk[32*k +: 32] = w;
                end
            end
            exp_blk.push_back(blk);
            res = blk + 128'd1;
            for (int k = 0; k < 4; k++) begin
                exp_out.push_back(res[32*k +: 32]);
                exp_out_blk.push_back(b);
                exp_out_last.push_back(k == 3 && b != exp_nblk - 1);
            end
        end
    endfunction

    // Plaintext source: one word per cycle from src while it lasts.
    initial begin
        bus.in_valid_i = 1'b0;
        bus.in_data_i  = '0;
        forever begin
            @(negedge clk);
            fire_in = bus.in_valid_i && bus.in_ready_o;
            @(posedge clk); #1;
            if (fire_in && src.size() > 0) void'(src.pop_front());
            bus.in_valid_i = (src.size() > 0);
            bus.in_data_i  = (src.size() > 0) ? src[0] : 32'h0;
        end
    end

    // Ciphertext sink with an optional stall window.
    initial begin
        bus.out_ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_left > 0 && out_seen >= stall_after) begin
                bus.out_ready_i = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready_i = 1'b1;
            end
        end
    end

    // AES core stand-in: answers block+1 five cycles after core_start_o.
    initial begin
        core_done_real = 1'b0;
        core_res_real  = '0;
        core_cnt       = 0;
        forever begin
            @(negedge clk);
            core_done_real = 1'b0;
            if (!reset_n) begin
                core_cnt = 0;
            end else if (bus.core_start_o) begin
                core_cnt = 5;
                core_in  = bus.core_block_o;
            end else if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    core_done_real = 1'b1;
                    core_res_real  = core_in + 128'd1;
                end
            end
        end
    end

    // Compare process against the model, every cycle.
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_ctrl", 128'({busy_o, done_o, bus.in_ready_o, bus.core_start_o, bus.out_valid_o}), 128'd0);
            chk("rst_blk_idx", 128'(blk_idx_o), 128'd0);
            chk("rst_core_block", bus.core_block_o, 128'd0);
            chk("rst_out_data", 128'(bus.out_data_o), 128'd0);
            prev_valid = 0; prev_ready = 0; prev_done = 0; ready_chk = 0;
        end else begin
            if (bus.core_start_o) begin
                starts++;
                obs_blk.push_back(bus.core_block_o);
                if (exp_blk.size() == 0) chk("core_start_unexpected", 128'd1, 128'd0);
                else chk("core_block", bus.core_block_o, exp_blk.pop_front());
            end
            if (bus.in_valid_i && bus.in_ready_o) fetched++;
            if (ready_chk) begin
                chk("next_block_ready", 128'(bus.in_ready_o), 128'd1);
                ready_chk = 0;
            end
            if (bus.out_valid_o && prev_valid && !prev_ready)
                chk("out_hold", 128'(bus.out_data_o), 128'(prev_data));
            if (bus.out_valid_o && bus.out_ready_i) begin
                out_seen++;
                obs_out.push_back(bus.out_data_o);
                if (exp_out.size() == 0) begin
                    chk("out_unexpected", 128'd1, 128'd0);
                end else begin
                    chk("out_data", 128'(bus.out_data_o), 128'(exp_out.pop_front()));
                    chk("out_blk_idx", 128'(blk_idx_o), 128'(exp_out_blk.pop_front()));
                    ready_chk = exp_out_last.pop_front();
                end
            end
            if (done_o) begin
                done_cnt++;
                done_idx = int'(blk_idx_o);
                chk("done_width", 128'(prev_done), 128'd0);
                chk("done_blk_idx", 128'(blk_idx_o), 128'(exp_nblk));
                chk("done_pending_out", 128'(exp_out.size()), 128'd0);
            end
            prev_valid = bus.out_valid_o;
            prev_ready = bus.out_ready_i;
            prev_data  = bus.out_data_o;
            prev_done  = done_o;
        end
    end

    task automatic flush();
        src.delete();
        exp_blk.delete(); exp_out.delete(); exp_out_blk.delete(); exp_out_last.delete();
    endtask

    task automatic prep_job(input logic [31:0] len, input int st_after, input int st_len);
        @(posedge clk); #1;
        flush();
        for (int i = 0; i < 10; i++) src.push_back(pool[i]);
        build_model(len);
        fetched = 0; starts = 0; done_cnt = 0; out_seen = 0;
        obs_out.delete(); obs_blk.delete();
        stall_after = st_after; stall_left = st_len;
        @(posedge clk); #1;
        byte_len_i = len;
        start_i    = 1'b1;
        @(posedge clk); #1;
        start_i    = 1'b0;
        byte_len_i = 32'hFFFF_FFFF;
    endtask

    task automatic run_job(input logic [31:0] len, input int st_after, input int st_len, input bit inject);
        int budget;
        prep_job(len, st_after, st_len);
        if (exp_nblk > 0) chk("start_to_ready", 128'(bus.in_ready_o), 128'd1);
        else chk("zero_len_done", 128'(done_o), 128'd1);
        if (inject) begin
            start_i    = 1'b1;
            byte_len_i = 32'd0;
            spur_done  = 1'b1;
            @(posedge clk); #1;
            start_i    = 1'b0;
            spur_done  = 1'b0;
        end
        budget = 0;
        while (done_cnt == 0 && budget < 2000) begin
            @(posedge clk); #2;
            budget++;
        end
        chk("job_timeout", 128'(budget < 2000), 128'd1);
        chk("done_one_cycle", 128'(done_o), 128'd0);
        chk("idle_after_done", 128'(busy_o), 128'd0);
        chk("fetch_count", 128'(fetched), 128'(exp_fetch));
        chk("core_starts", 128'(starts), 128'(exp_nblk));
        chk("out_left", 128'(exp_out.size()), 128'd0);
        chk("done_count", 128'(done_cnt), 128'd1);
    endtask

    initial begin
        int budget;
        reset_n = 1'b0; clear = 1'b0; start_i = 1'b0; byte_len_i = '0; spur_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 128'(busy_o), 128'd0);
        reset_n = 1'b1;

        // Two blocks of words 1..8.
        for (int i = 0; i < 10; i++) pool[i] = 32'(i + 1);
        run_job(32'd32, 0, 0, 1'b0);
        chk("j32_out0", 128'(obs_out[0]), 128'h2);
        chk("j32_out4", 128'(obs_out[4]), 128'h6);
        chk("j32_blk1", obs_blk[1], 128'h00000008_00000007_00000006_00000005);
        chk("j32_fetched", 128'(fetched), 128'd8);
        chk("j32_final_idx", 128'(done_idx), 128'd2);

        // Zero length.
        run_job(32'd0, 0, 0, 1'b0);
        chk("j0_fetched", 128'(fetched), 128'd0);
        chk("j0_starts", 128'(starts), 128'd0);

        // Output stall mid-drain.
        for (int i = 0; i < 10; i++) pool[i] = 32'h0101_0101 * 32'(i + 1);
        run_job(32'd32, 2, 10, 1'b0);
        chk("stall_words", 128'(out_seen), 128'd8);

        // Length not a multiple of 16.
        for (int i = 0; i < 10; i++) pool[i] = 32'hA500_0000 + 32'(i);
        run_job(32'd20, 0, 0, 1'b0);
`ifdef AES_BLOCK_SEQ_PADDING_EN
        chk("j20_fetched", 128'(fetched), 128'd5);
        chk("j20_starts", 128'(starts), 128'd2);
        chk("j20_blk1", obs_blk[1], 128'h00000000_00000000_00000000_A5000004);
`else
        chk("j20_fetched", 128'(fetched), 128'd4);
        chk("j20_starts", 128'(starts), 128'd1);
`endif

        // Start while busy and spurious core_done in LOAD; carry across words.
        pool[0] = 32'hFFFF_FFFF; pool[1] = 32'h1234_5678;
        for (int i = 2; i < 10; i++) pool[i] = 32'hC0DE_0000 + 32'(i);
        run_job(32'd32, 0, 0, 1'b1);
        chk("spur_out0", 128'(obs_out[0]), 128'h0);
        chk("spur_out1", 128'(obs_out[1]), 128'h12345679);

        // Reset during WAIT_CORE, then a fresh 16-byte job.
        for (int i = 0; i < 10; i++) pool[i] = 32'h5A5A_0000 + 32'(i);
        prep_job(32'd32, 0, 0);
        budget = 0;
        while (starts == 0 && budget < 200) begin
            @(posedge clk); #2;
            budget++;
        end
        chk("wait_core_start", 128'(budget < 200), 128'd1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_busy", 128'(busy_o), 128'd0);
        repeat (3) @(posedge clk);
        #1;
        flush();
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("no_stale_done", 128'(done_cnt), 128'd0);
        run_job(32'd16, 0, 0, 1'b0);

        // clear during LOAD together with start_i.
        prep_job(32'd32, 0, 0);
        @(posedge clk); #1;
        clear      = 1'b1;
        start_i    = 1'b1;
        byte_len_i = 32'd32;
        @(posedge clk); #1;
        clear   = 1'b0;
        start_i = 1'b0;
        chk("clear_idle", 128'(busy_o), 128'd0);
        chk("clear_ready", 128'(bus.in_ready_o), 128'd0);
        chk("clear_block", bus.core_block_o, 128'd0);
        chk("clear_blk_idx", 128'(blk_idx_o), 128'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("clear_no_done", 128'(done_cnt), 128'd0);
        chk("clear_still_idle", 128'(busy_o), 128'd0);
        flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
